lzc_normalize_pipe: RTL and testbench
=====================================

Name: lzc_normalize_pipe

Overview:
Two-stage pipelined normalizer. It finds the leading-zero count of a 32-bit word and left-shifts the word so that its MSB is 1.
It sits in the datapath directly upstream of the variable logical left-shift stage and feeds that stage's shift_n_i/val_i operands. It also delivers the normalized value itself, so the consumer can either check the shift or bypass it.
A valid/ready handshake on both sides allows the block to be stalled by a downstream consumer.

Parameters:
WIDTH, 32, data width in bits; must be a power of two, at least 2.
SHIFT_W, $clog2(WIDTH), width of the shift amount (5 at default).

Ports:
clk_i  input  1  clock; all state updates on the rising edge.
rst_ni  input  1  asynchronous active-low reset.
valid_i  input  1  upstream presents val_i.
ready_o  output  1  block accepts val_i this cycle.
val_i  input  WIDTH  word to normalize.
valid_o  output  1  result outputs are valid.
ready_i  input  1  downstream accepts the result this cycle.
shift_n_o  output  SHIFT_W  leading-zero count of the accepted word.
norm_o  output  WIDTH  accepted word shifted left by shift_n_o, zero-filled.
zero_o  output  1  accepted word was all zeros.

Behaviour:
- Reset (async assert, sync-safe release): s1_valid=0, s2_valid=0, valid_o=0, shift_n_o=0, norm_o=0, zero_o=0. ready_o is 1 out of reset.
- Stage 1 (S1) registers: val, lzc (SHIFT_W bits), zero flag. The count is computed combinationally from val_i on acceptance.
- Stage 2 (S2) registers: norm = S1.val << S1.lzc, plus lzc and zero copied forward. The S2 registers drive the outputs directly.
- Advance rules:
  - adv2 = !s2_valid | ready_i
  - adv1 = !s1_valid | adv2
  - ready_o = adv1 (combinational path from ready_i; accepted at this width).
- Input transfer on valid_i & ready_o. S1 loads, and s1_valid <= valid_i whenever adv1.
- S2 loads from S1, and s2_valid <= s1_valid whenever adv2.
- Output transfer on valid_o & ready_i.
- Latency: 2 cycles from input transfer to valid_o with no stall. Throughput is 1 word per cycle with ready_i held high.
- Stall: while valid_o=1 and ready_i=0, the S2 outputs hold stable. S1 holds if it is occupied. ready_o drops only when both stages are full.
- All-zero input: zero_o=1, shift_n_o=0, norm_o=0. The full count of WIDTH is not representable, so the shift is forced to 0.
- MSB set: shift_n_o=0 and norm_o=val_i.
- Priority encoding is MSB-first. The count is the index distance from bit WIDTH-1 down to the first 1.
- Holding registers are not cleared when a stage empties. The outputs are don't-care while valid_o=0.
- Reset asserted mid-operation discards all in-flight words immediately. No partial outputs appear after release.
- valid_i asserted while ready_o=0: the word is not taken. The upstream must hold it stable (standard handshake).

Decomposition:
- Shared package (normalize_pkg): WIDTH default, SHIFT_W constant, and a struct typedef norm_res_t {norm, lzc, zero} used for the S2 register and by downstream consumers.
- One sub-module, lzc32: a combinational leading-zero counter producing {cnt[SHIFT_W-1:0], all_zero}. It is built as a log-depth tree, so the counter is reusable elsewhere in the datapath.
- The shift in S2 is inline, with no separate instance.

Test Plan:
- Reset, then val_i=0x00000001 with ready_i=1 -> two cycles later: valid_o=1, shift_n_o=31, norm_o=0x80000000, zero_o=0.
- Back-to-back inputs 0x00F00000, 0x80000000, 0x00000000 -> three consecutive valid_o cycles:
  - shift 8, norm 0xF0000000, zero 0
  - shift 0, norm 0x80000000, zero 0
  - shift 0, norm 0x00000000, zero 1
- Backpressure: stream 0x1, 0x2, 0x4, 0x8 with ready_i=0 for cycles 3-6:
  - ready_o drops once both stages are full; outputs are held stable.
  - After ready_i=1, results emerge in order (shift 31, 30, 29, 28) with no loss or duplication.
- Randomized valid_i/ready_i over 10k words -> a scoreboard checks norm_o == val<<shift_n_o, norm_o[31]==1 for nonzero words, and ordering.
- rst_ni pulled low for 1 cycle while two words are in flight -> valid_o=0 at once. The first valid_o after release belongs to a word accepted after release.
- Single-word hold: valid_o=1 with ready_i=0 for 5 cycles -> shift_n_o, norm_o and zero_o are unchanged on every cycle. The output transfer occurs on the cycle ready_i rises.

Source files
------------

// File: rtl/normalize_pkg.sv
// Shared constants and result type for the leading-zero normalizer datapath.
package normalize_pkg;

    localparam int WIDTH   = 32;
    localparam int SHIFT_W = $clog2(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0]   norm;
        logic [SHIFT_W-1:0] lzc;
        logic               zero;
    } norm_res_t;

endpackage

// File: rtl/lzc32.sv
// Combinational MSB-first leading-zero counter built as a log-depth merge tree.
// An all-zero word reports cnt_o=0 with zero_o=1.
module lzc32 #(
    parameter int  WIDTH = normalize_pkg::WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] val_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    // Level l holds WIDTH>>l nodes, each covering 2^l bits with an l-bit count.
    // When the upper half is empty the count is half-width plus the lower count,
    // which is just the lower count with a 1 prepended.
    for (genvar l = 1; l <= CNT_W; l++) begin : g_lvl
        localparam int N = WIDTH >> l;
        logic [N-1:0][l-1:0] cnt;
        logic [N-1:0]        z;
        for (genvar j = 0; j < N; j++) begin : g_node
            if (l == 1) begin : g_leaf
                assign z[j]   = ~val_i[2*j+1] & ~val_i[2*j];
                assign cnt[j] = ~val_i[2*j+1];
            end else begin : g_merge
                assign z[j]   = g_lvl[l-1].z[2*j+1] & g_lvl[l-1].z[2*j];
                assign cnt[j] = g_lvl[l-1].z[2*j+1] ? {1'b1, g_lvl[l-1].cnt[2*j]}
                                                    : {1'b0, g_lvl[l-1].cnt[2*j+1]};
            end
        end
    end

    assign zero_o = g_lvl[CNT_W].z[0];
    assign cnt_o  = zero_o ? '0 : g_lvl[CNT_W].cnt[0];

endmodule

// File: rtl/lzc_normalize_pipe.sv
// Two-stage valid/ready normalizer: S1 registers the word and its leading-zero
// count, S2 registers the left-shifted result that drives the outputs.
module lzc_normalize_pipe
    import normalize_pkg::*;
#(
    parameter int WIDTH   = normalize_pkg::WIDTH,
    parameter int SHIFT_W = $clog2(WIDTH)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [WIDTH-1:0]   val_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [SHIFT_W-1:0] shift_n_o,
    output logic [WIDTH-1:0]   norm_o,
    output logic               zero_o
);

    logic               adv1, adv2;
    logic               s1_valid_q, s2_valid_q;
    logic [WIDTH-1:0]   s1_val_q;
    logic [SHIFT_W-1:0] s1_lzc_q;
    logic               s1_zero_q;
    logic [SHIFT_W-1:0] lzc_d;
    logic               zero_d;
    // S2 uses the shared result struct, so WIDTH must stay at the package value.
    norm_res_t          s2_q;

    lzc32 #(.WIDTH(WIDTH)) u_lzc (
        .val_i  (val_i),
        .cnt_o  (lzc_d),
        .zero_o (zero_d)
    );

    assign adv2    = ~s2_valid_q | ready_i;
    assign adv1    = ~s1_valid_q | adv2;
    assign ready_o = adv1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_val_q   <= '0;
            s1_lzc_q   <= '0;
            s1_zero_q  <= 1'b0;
        end else if (adv1) begin
            s1_valid_q <= valid_i;
            if (valid_i) begin
                s1_val_q  <= val_i;
                s1_lzc_q  <= lzc_d;
                s1_zero_q <= zero_d;
            end
        end
    end

    // Payload only moves with a real word so an emptied S2 keeps its last result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid_q <= 1'b0;
            s2_q       <= '0;
        end else if (adv2) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_q.norm <= s1_val_q << s1_lzc_q;
                s2_q.lzc  <= s1_lzc_q;
                s2_q.zero <= s1_zero_q;
            end
        end
    end

    assign valid_o   = s2_valid_q;
    assign shift_n_o = s2_q.lzc;
    assign norm_o    = s2_q.norm;
    assign zero_o    = s2_q.zero;

endmodule

// File: tb/tb_lzc_normalize_pipe.sv
// Directed and randomized checks of lzc_normalize_pipe against a bit-loop reference.
module tb_lzc_normalize_pipe;

    localparam int W  = 32;
    localparam int SW = 5;

    logic          clk_i = 1'b0;
    logic          rst_ni, valid_i, ready_i;
    logic [W-1:0]  val_i;
    logic          ready_o, valid_o, zero_o;
    logic [SW-1:0] shift_n_o;
    logic [W-1:0]  norm_o;

    int n_cmp = 0;
    int n_bad = 0;

    // bench model of the pipeline: occupancy and in-order word queue
    logic          s1v = 1'b0, s2v = 1'b0;
    logic [W-1:0]  q[$];
    logic          hold_v = 1'b0;
    logic [SW-1:0] h_s;
    logic [W-1:0]  h_n;
    logic          h_z;
    logic [SW-1:0] emitted[$];

    always #5 clk_i = ~clk_i;

    lzc_normalize_pipe dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .val_i     (val_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .shift_n_o (shift_n_o),
        .norm_o    (norm_o),
        .zero_o    (zero_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_norm(input logic [W-1:0] v, output logic [SW-1:0] s,
                                     output logic [W-1:0] n, output logic z);
        int k;
        z = (v == '0);
        k = 0;
        if (!z) while (!v[W-1-k]) k++;
        s = SW'(k);
        n = v << k;
    endfunction

    // One cycle from a negedge: drive, check against the model, advance the model.
    task automatic step(input logic vin, input logic [W-1:0] v, input logic rdy, output logic took);
        logic [SW-1:0] es;
        logic [W-1:0]  en;
        logic          ez, a1, a2;
        valid_i = vin; val_i = v; ready_i = rdy;
        #1;
        a2 = !s2v || rdy;
        a1 = !s1v || a2;
        chk("ready_o", ready_o, a1);
        chk("valid_o", valid_o, s2v);
        if (hold_v) begin
            chk("hold_shift", shift_n_o, h_s);
            chk("hold_norm", norm_o, h_n);
            chk("hold_zero", zero_o, h_z);
        end
        if (s2v && q.size() > 0) begin
            ref_norm(q[0], es, en, ez);
            chk("shift_n_o", shift_n_o, es);
            chk("norm_o", norm_o, en);
            chk("zero_o", zero_o, ez);
            if (!ez) chk("norm_msb", norm_o[W-1], 1'b1);
        end
        hold_v = s2v && !rdy;
        h_s = shift_n_o; h_n = norm_o; h_z = zero_o;
        if (s2v && rdy && q.size() > 0) begin
            void'(q.pop_front());
            emitted.push_back(shift_n_o);
        end
        took = vin && a1;
        if (took) q.push_back(v);
        if (a2) s2v = s1v;
        if (a1) s1v = vin;
        @(negedge clk_i);
    endtask

    task automatic model_reset();
        s1v = 1'b0; s2v = 1'b0; hold_v = 1'b0;
        q.delete();
        emitted.delete();
    endtask

    initial begin
        logic          took, pv;
        logic [W-1:0]  pw;
        logic [W-1:0]  vec[3];
        logic [SW-1:0] exp_s[3];
        logic [W-1:0]  exp_n[3];
        logic          exp_z[3];
        logic [SW-1:0] exp_bp[4];
        logic          saw_low;
        int            sent, cyc;

        rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b0; val_i = '0;
        #1;
        chk("rst_valid_o", valid_o, 1'b0);
        chk("rst_shift", shift_n_o, 5'd0);
        chk("rst_norm", norm_o, 32'h0);
        chk("rst_zero", zero_o, 1'b0);
        chk("rst_ready_o", ready_o, 1'b1);
        @(negedge clk_i); @(negedge clk_i);
        rst_ni = 1'b1;

        // single word, two-cycle latency
        valid_i = 1'b1; val_i = 32'h0000_0001; ready_i = 1'b1;
        @(negedge clk_i);
        valid_i = 1'b0; #1;
        chk("lat1_valid_o", valid_o, 1'b0);
        @(negedge clk_i); #1;
        chk("lat2_valid_o", valid_o, 1'b1);
        chk("lat2_shift", shift_n_o, 5'd31);
        chk("lat2_norm", norm_o, 32'h8000_0000);
        chk("lat2_zero", zero_o, 1'b0);
        @(negedge clk_i); #1;
        chk("drain_valid_o", valid_o, 1'b0);
        @(negedge clk_i);

        // back-to-back words
        vec[0] = 32'h00F0_0000; exp_s[0] = 5'd8; exp_n[0] = 32'hF000_0000; exp_z[0] = 1'b0;
        vec[1] = 32'h8000_0000; exp_s[1] = 5'd0; exp_n[1] = 32'h8000_0000; exp_z[1] = 1'b0;
        vec[2] = 32'h0000_0000; exp_s[2] = 5'd0; exp_n[2] = 32'h0000_0000; exp_z[2] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            valid_i = (i < 3); val_i = (i < 3) ? vec[i] : '0; ready_i = 1'b1;
            #1;
            if (i >= 2) begin
                chk("b2b_valid_o", valid_o, 1'b1);
                chk("b2b_shift", shift_n_o, exp_s[i-2]);
                chk("b2b_norm", norm_o, exp_n[i-2]);
                chk("b2b_zero", zero_o, exp_z[i-2]);
            end
            @(negedge clk_i);
        end
        valid_i = 1'b0; #1;
        chk("b2b_end_valid_o", valid_o, 1'b0);
        @(negedge clk_i);
        model_reset();

        // backpressure: ready_i low for cycles 3..6
        exp_bp[0] = 5'd31; exp_bp[1] = 5'd30; exp_bp[2] = 5'd29; exp_bp[3] = 5'd28;
        sent = 0; saw_low = 1'b0;
        for (int c = 0; c < 16; c++) begin
            pw = 32'h1 << sent;
            step(sent < 4, pw, !(c >= 3 && c <= 6), took);
            if (took) sent++;
            if (!ready_o) saw_low = 1'b1;
        end
        chk("bp_ready_dropped", saw_low, 1'b1);
        chk("bp_count", emitted.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < emitted.size()) chk("bp_order", emitted[i], exp_bp[i]);
        model_reset();

        // single-word hold for 5 cycles, transfer on the cycle ready_i rises
        step(1'b1, 32'h0001_0000, 1'b1, took);
        for (int c = 0; c < 6; c++) step(1'b0, '0, 1'b0, took);
        step(1'b0, '0, 1'b1, took);
        chk("hold_emit_count", emitted.size(), 1);
        if (emitted.size() > 0) chk("hold_emit_shift", emitted[0], 5'd15);
        step(1'b0, '0, 1'b1, took);
        model_reset();

        // reset with two words in flight
        step(1'b1, 32'h0000_0100, 1'b1, took);
        step(1'b1, 32'h0000_0200, 1'b1, took);
        rst_ni = 1'b0; valid_i = 1'b0; #1;
        chk("midrst_valid_o", valid_o, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
        step(1'b0, '0, 1'b1, took);
        step(1'b0, '0, 1'b1, took);
        step(1'b1, 32'h0000_4000, 1'b1, took);
        for (int c = 0; c < 3; c++) step(1'b0, '0, 1'b1, took);
        chk("midrst_emit_count", emitted.size(), 1);
        if (emitted.size() > 0) chk("midrst_emit_shift", emitted[0], 5'd17);
        model_reset();

        // randomized handshake with held offers
        sent = 0; pv = 1'b0; pw = '0; cyc = 0;
        while (sent < 10000 && cyc < 60000) begin
            if (!pv) begin
                pv = ($urandom_range(0, 3) != 0);
                pw = $urandom >> $urandom_range(0, 32);
            end
            step(pv, pw, $urandom_range(0, 3) != 0, took);
            if (took) begin pv = 1'b0; sent++; end
            cyc++;
        end
        chk("rnd_sent", sent, 10000);
        for (int c = 0; c < 4; c++) step(1'b0, '0, 1'b1, took);
        chk("rnd_drained", q.size(), 0);
        chk("rnd_emitted", emitted.size(), 10000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
